// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the round-robin FIFO write-port arbiter.
package fifo_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Burst counter must hold the value BURST_LEN itself, and never collapse to zero width.
    function automatic int burst_cnt_width(input int burst_len);
        int w;
        w = $clog2(burst_len + 32'sd1);
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-port bundle seen by the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       grant;
    logic [IW-1:0]            owner_id;
    logic                     owner_valid;
    logic [WIDTH-1:0]         wdata;
    logic                     wr_en;
    logic                     full_flag;

    modport master (
        input  req, req_data, full_flag,
        output req_ready, grant, owner_id, owner_valid, wdata, wr_en
    );

    modport slave (
        output req, req_data, full_flag,
        input  req_ready, grant, owner_id, owner_valid, wdata, wr_en
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: first set request at or above ptr, with wrap.
module fifo_wr_arbiter_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    logic [IW:0] cand_s;

    // Scan offsets from highest to lowest so the nearest request to ptr is the last one written.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        cand_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand_s = {1'b0, ptr} + (IW + 1)'(i);
            cand_s = (cand_s >= (IW + 1)'(NUM_REQ)) ? (cand_s - (IW + 1)'(NUM_REQ)) : cand_s;
            idx    = req[cand_s[IW-1:0]] ? cand_s[IW-1:0] : idx;
            any    = any | req[cand_s[IW-1:0]];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bursts.
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input logic                clk,
    input logic                rst,
    fifo_wr_arbiter_if.master  bus
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = burst_cnt_width(BURST_LEN);

    arb_state_e         state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [IW-1:0]      owner_id_r;
    logic               owner_valid_r;
    logic [IW-1:0]      rr_ptr_r;
    logic [CW-1:0]      burst_cnt_r;

    logic               pick_any_s;
    logic [IW-1:0]      pick_idx_s;
    logic               owner_req_s;
    logic               xfer_s;
    logic [CW-1:0]      cnt_next_s;
    logic [IW-1:0]      ptr_next_s;
    logic [WIDTH-1:0]   wdata_s;

    fifo_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req (bus.req),
        .ptr (rr_ptr_r),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // full_flag gates the write path combinationally so the fifo never sees wr_en while full.
    assign owner_req_s = bus.req[owner_id_r];
    assign xfer_s      = (state_r == BUSY) && owner_req_s && !bus.full_flag;
    assign cnt_next_s  = burst_cnt_r + CW'(1);
    assign ptr_next_s  = (owner_id_r == IW'(NUM_REQ - 1)) ? IW'(0) : (owner_id_r + IW'(1));

    // Route the owner's word to the fifo while busy; drive zero when idle.
    always_comb begin
        wdata_s = '0;
        case (state_r)
            BUSY:    wdata_s = bus.req_data[owner_id_r*WIDTH +: WIDTH];
            default: wdata_s = '0;
        endcase
    end

    assign bus.wr_en       = xfer_s;
    assign bus.req_ready   = ((state_r == BUSY) && !bus.full_flag) ? grant_r : '0;
    assign bus.wdata       = wdata_s;
    assign bus.grant       = grant_r;
    assign bus.owner_id    = owner_id_r;
    assign bus.owner_valid = owner_valid_r;

    // Arbitration FSM: grant in IDLE, count burst words in BUSY, release on burst end or request drop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= IDLE;
            grant_r       <= '0;
            owner_id_r    <= '0;
            owner_valid_r <= 1'b0;
            rr_ptr_r      <= '0;
            burst_cnt_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        grant_r       <= NUM_REQ'(1) << pick_idx_s;
                        owner_id_r    <= pick_idx_s;
                        owner_valid_r <= 1'b1;
                        burst_cnt_r   <= '0;
                        state_r       <= BUSY;
                    end
                end
                BUSY: begin
                    if (!owner_req_s || (xfer_s && (cnt_next_s == CW'(BURST_LEN)))) begin
                        rr_ptr_r      <= ptr_next_s;
                        grant_r       <= '0;
                        owner_id_r    <= '0;
                        owner_valid_r <= 1'b0;
                        burst_cnt_r   <= '0;
                        state_r       <= IDLE;
                    end else if (xfer_s) begin
                        burst_cnt_r   <= cnt_next_s;
                    end
                end
                default: begin
                    grant_r       <= '0;
                    owner_id_r    <= '0;
                    owner_valid_r <= 1'b0;
                    burst_cnt_r   <= '0;
                    state_r       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a 4-producer instance plus a 3-producer instance for pointer wrap.
module tb_fifo_wr_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    fifo_wr_arbiter_if #(.NUM_REQ(4), .WIDTH(32)) bus4 ();
    fifo_wr_arbiter_if #(.NUM_REQ(3), .WIDTH(32)) bus3 ();

    fifo_wr_arbiter #(.NUM_REQ(4), .WIDTH(32), .BURST_LEN(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(32), .BURST_LEN(4)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word4(input int i, input logic [31:0] w);
        bus4.req_data[i*32 +: 32] = w;
    endtask

    task automatic set_word3(input int i, input logic [31:0] w);
        bus3.req_data[i*32 +: 32] = w;
    endtask

    // Continuous invariants on the 4-producer instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check_eq("grant_onehot0", 64'($onehot0(bus4.grant)), 64'd1);
            check_eq("wr_en_while_full", 64'(bus4.wr_en & bus4.full_flag), 64'd0);
            check_eq("wr_en_without_owner", 64'(bus4.wr_en & ~bus4.owner_valid), 64'd0);
        end
    end

    initial begin
        rst            = 1'b0;
        bus4.req       = 4'b0000;
        bus4.req_data  = '0;
        bus4.full_flag = 1'b0;
        bus3.req       = 3'b000;
        bus3.req_data  = '0;
        bus3.full_flag = 1'b0;

        // Reset state, with requests present that must be ignored.
        bus4.req = 4'b1111;
        #1;
        check_eq("rst_grant", 64'(bus4.grant), 64'd0);
        check_eq("rst_owner_id", 64'(bus4.owner_id), 64'd0);
        check_eq("rst_owner_valid", 64'(bus4.owner_valid), 64'd0);
        check_eq("rst_wr_en", 64'(bus4.wr_en), 64'd0);
        check_eq("rst_req_ready", 64'(bus4.req_ready), 64'd0);
        check_eq("rst_wdata", 64'(bus4.wdata), 64'd0);
        step();
        step();
        check_eq("rst_held_grant", 64'(bus4.grant), 64'd0);
        check_eq("rst_held_wr_en", 64'(bus4.wr_en), 64'd0);
        bus4.req = 4'b0000;
        rst      = 1'b1;
        step();

        // Single producer 2: four words, one bubble, regrant for the last two.
        bus4.req = 4'b0100;
        set_word4(2, 32'hA0A0_0001);
        #1;
        check_eq("sp_pre_grant", 64'(bus4.grant), 64'd0);
        check_eq("sp_pre_wr_en", 64'(bus4.wr_en), 64'd0);
        step();
        for (int k = 1; k <= 4; k++) begin
            set_word4(2, 32'hA0A0_0000 + 32'(k));
            #1;
            check_eq("sp_grant", 64'(bus4.grant), 64'h4);
            check_eq("sp_wr_en", 64'(bus4.wr_en), 64'd1);
            check_eq("sp_wdata", 64'(bus4.wdata), 64'hA0A0_0000 + 64'(k));
            check_eq("sp_req_ready", 64'(bus4.req_ready), 64'h4);
            if (k == 1) begin
                check_eq("sp_owner_id", 64'(bus4.owner_id), 64'd2);
                check_eq("sp_owner_valid", 64'(bus4.owner_valid), 64'd1);
            end
            step();
        end
        set_word4(2, 32'hA0A0_0005);
        #1;
        check_eq("sp_bubble_grant", 64'(bus4.grant), 64'd0);
        check_eq("sp_bubble_wr_en", 64'(bus4.wr_en), 64'd0);
        check_eq("sp_bubble_valid", 64'(bus4.owner_valid), 64'd0);
        check_eq("sp_bubble_wdata", 64'(bus4.wdata), 64'd0);
        step();
        for (int k = 5; k <= 6; k++) begin
            set_word4(2, 32'hA0A0_0000 + 32'(k));
            #1;
            check_eq("sp2_grant", 64'(bus4.grant), 64'h4);
            check_eq("sp2_wr_en", 64'(bus4.wr_en), 64'd1);
            check_eq("sp2_wdata", 64'(bus4.wdata), 64'hA0A0_0000 + 64'(k));
            step();
        end
        bus4.req = 4'b0000;
        #1;
        check_eq("sp_drop_wr_en", 64'(bus4.wr_en), 64'd0);
        check_eq("sp_drop_grant", 64'(bus4.grant), 64'h4);
        step();
        check_eq("sp_end_grant", 64'(bus4.grant), 64'd0);

        // Asynchronous reset pulse mid-cycle brings rr_ptr back to 0.
        #1;
        rst = 1'b0;
        #1;
        rst = 1'b1;

        // All four requesting: grants 0,1,2,3,0 with four words each and one bubble between.
        for (int i = 0; i < 4; i++) set_word4(i, 32'hB000_0000 + 32'(i));
        bus4.req = 4'b1111;
        #1;
        check_eq("rr_idle_wr_en", 64'(bus4.wr_en), 64'd0);
        for (int g = 0; g < 5; g++) begin
            step();
            for (int w = 0; w < 4; w++) begin
                #1;
                check_eq("rr_grant", 64'(bus4.grant), 64'd1 << (g % 4));
                check_eq("rr_wr_en", 64'(bus4.wr_en), 64'd1);
                check_eq("rr_wdata", 64'(bus4.wdata), 64'hB000_0000 + 64'(g % 4));
                step();
            end
            #1;
            check_eq("rr_bubble_grant", 64'(bus4.grant), 64'd0);
            check_eq("rr_bubble_wr_en", 64'(bus4.wr_en), 64'd0);
        end
        bus4.req = 4'b0000;

        // Full stall: owner 1 writes two words, fifo full for five cycles, then two more words.
        bus4.req = 4'b0010;
        set_word4(1, 32'hC0C0_0001);
        step();
        for (int k = 1; k <= 2; k++) begin
            set_word4(1, 32'hC0C0_0000 + 32'(k));
            #1;
            check_eq("fs_wr_en", 64'(bus4.wr_en), 64'd1);
            check_eq("fs_wdata", 64'(bus4.wdata), 64'hC0C0_0000 + 64'(k));
            step();
        end
        bus4.full_flag = 1'b1;
        set_word4(1, 32'hC0C0_0003);
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("fs_stall_wr_en", 64'(bus4.wr_en), 64'd0);
            check_eq("fs_stall_ready", 64'(bus4.req_ready), 64'd0);
            check_eq("fs_stall_grant", 64'(bus4.grant), 64'h2);
            step();
        end
        bus4.full_flag = 1'b0;
        for (int k = 3; k <= 4; k++) begin
            set_word4(1, 32'hC0C0_0000 + 32'(k));
            #1;
            check_eq("fs_resume_wr_en", 64'(bus4.wr_en), 64'd1);
            check_eq("fs_resume_wdata", 64'(bus4.wdata), 64'hC0C0_0000 + 64'(k));
            check_eq("fs_resume_ready", 64'(bus4.req_ready), 64'h2);
            step();
        end
        #1;
        check_eq("fs_release_grant", 64'(bus4.grant), 64'd0);
        check_eq("fs_release_wr_en", 64'(bus4.wr_en), 64'd0);
        bus4.req = 4'b0000;

        // Early drop: owner 3 drops after one word; pending producer 0 wins next.
        bus4.req = 4'b1001;
        set_word4(3, 32'hD0D0_0001);
        set_word4(0, 32'hE0E0_0001);
        step();
        #1;
        check_eq("ed_grant", 64'(bus4.grant), 64'h8);
        check_eq("ed_wdata", 64'(bus4.wdata), 64'hD0D0_0001);
        check_eq("ed_wr_en", 64'(bus4.wr_en), 64'd1);
        step();
        bus4.req = 4'b0001;
        #1;
        check_eq("ed_drop_wr_en", 64'(bus4.wr_en), 64'd0);
        check_eq("ed_drop_grant", 64'(bus4.grant), 64'h8);
        step();
        check_eq("ed_bubble_grant", 64'(bus4.grant), 64'd0);
        check_eq("ed_bubble_wr_en", 64'(bus4.wr_en), 64'd0);
        step();
        check_eq("ed_next_grant", 64'(bus4.grant), 64'h1);
        check_eq("ed_next_wdata", 64'(bus4.wdata), 64'hE0E0_0001);
        check_eq("ed_next_wr_en", 64'(bus4.wr_en), 64'd1);
        bus4.req = 4'b0000;
        #1;
        check_eq("ed_end_wr_en", 64'(bus4.wr_en), 64'd0);
        step();

        // Reset during owner 2's third word, then lowest requester wins after reset.
        bus4.req = 4'b0100;
        set_word4(2, 32'hF0F0_0001);
        step();
        for (int k = 1; k <= 2; k++) begin
            set_word4(2, 32'hF0F0_0000 + 32'(k));
            #1;
            check_eq("rm_grant", 64'(bus4.grant), 64'h4);
            step();
        end
        set_word4(2, 32'hF0F0_0003);
        #1;
        check_eq("rm_third_wr_en", 64'(bus4.wr_en), 64'd1);
        rst = 1'b0;
        #1;
        check_eq("rm_async_wr_en", 64'(bus4.wr_en), 64'd0);
        check_eq("rm_async_ready", 64'(bus4.req_ready), 64'd0);
        check_eq("rm_async_grant", 64'(bus4.grant), 64'd0);
        check_eq("rm_async_valid", 64'(bus4.owner_valid), 64'd0);
        bus4.req = 4'b0101;
        set_word4(0, 32'h1111_0000);
        step();
        check_eq("rm_held_grant", 64'(bus4.grant), 64'd0);
        check_eq("rm_held_wr_en", 64'(bus4.wr_en), 64'd0);
        rst = 1'b1;
        #1;
        step();
        check_eq("rm_after_grant", 64'(bus4.grant), 64'h1);
        check_eq("rm_after_owner_id", 64'(bus4.owner_id), 64'd0);
        check_eq("rm_after_wdata", 64'(bus4.wdata), 64'h1111_0000);
        bus4.req = 4'b0000;
        step();

        // NUM_REQ=3: owner 2 releases, rr_ptr wraps to 0, then 0 then 1 are granted.
        bus3.req = 3'b100;
        set_word3(2, 32'h3333_0002);
        step();
        check_eq("w3_grant2", 64'(bus3.grant), 64'h4);
        check_eq("w3_wdata2", 64'(bus3.wdata), 64'h3333_0002);
        bus3.req = 3'b011;
        set_word3(0, 32'h3333_0000);
        set_word3(1, 32'h3333_0001);
        #1;
        check_eq("w3_drop_wr_en", 64'(bus3.wr_en), 64'd0);
        step();
        check_eq("w3_bubble_grant", 64'(bus3.grant), 64'd0);
        step();
        check_eq("w3_grant0", 64'(bus3.grant), 64'h1);
        check_eq("w3_owner0", 64'(bus3.owner_id), 64'd0);
        for (int k = 0; k < 4; k++) step();
        check_eq("w3_bubble2_grant", 64'(bus3.grant), 64'd0);
        step();
        check_eq("w3_grant1", 64'(bus3.grant), 64'h2);
        check_eq("w3_owner1", 64'(bus3.owner_id), 64'd1);
        check_eq("w3_wdata1", 64'(bus3.wdata), 64'h3333_0001);
        bus3.req = 3'b000;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
